// File: rtl/dense_result_argmax.sv
// rtl/dense_result_argmax.sv - sequential argmax reader for the final dense layer results
//
// Reads `out` signed result words starting at `memstartzap` from pixel memory,
// tracks the running maximum and reports the index of the winning class.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   result_en       level enable; high starts/holds a scan, low aborts to IDLE
//   out             number of results to scan (0..15), sampled at scan start
//   memstartzap     base address of the result vector, sampled at scan start
//   re_p            memory read enable
//   read_addressp   memory read address (wraps modulo 2^SIZE_address_pix)
//   qp              memory read data, valid RD_LATENCY edges after sampling
//   STOP            scan complete, held while result_en stays high
//   RESULT          index of the maximum result
//   max_val         value of the maximum result
//
// Optional build macro: RESULT_NODETECT_EN
//   When defined, RESULT reads 4'hF ("no digit") if the final maximum is <= 0.

module dense_result_argmax #(
   parameter int SIZE_1           = 11,
   parameter int SIZE_address_pix = 13,
   parameter int RD_LATENCY       = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        result_en,
   input  logic [3:0]                  out,
   input  logic [SIZE_address_pix-1:0] memstartzap,
   output logic                        re_p,
   output logic [SIZE_address_pix-1:0] read_addressp,
   input  logic signed [SIZE_1-1:0]    qp,
   output logic                        STOP,
   output logic [3:0]                  RESULT,
   output logic signed [SIZE_1-1:0]    max_val
);

   localparam int PL = RD_LATENCY + 1;
   localparam logic signed [SIZE_1-1:0] MOST_NEG = {1'b1, {(SIZE_1-1){1'b0}}};
   // Tag stages that must be empty before DONE is entered. The last issued
   // read is allowed to sit in the final stage, so its compare lands on the
   // same edge that raises STOP.
   localparam logic [PL-1:0] DRAIN_MASK = PL'((1 << (RD_LATENCY - 1)) - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                      state, state_nxt;
   logic [3:0]                  k;
   logic [3:0]                  cnt;
   logic [SIZE_address_pix-1:0] base;
   logic [PL-1:0]               tag_v;
   logic [3:0]                  tag_i [PL];

   logic                        hit;
   logic signed [SIZE_1-1:0]    max_nxt;
   logic [3:0]                  idx_nxt;
   logic [3:0]                  result_done;

   always_comb begin
      state_nxt   = state;
      hit         = tag_v[RD_LATENCY] && (qp > max_val);
      max_nxt     = hit ? qp : max_val;
      idx_nxt     = hit ? tag_i[RD_LATENCY] : RESULT;
`ifdef RESULT_NODETECT_EN
      result_done = (max_nxt <= 0) ? 4'hF : idx_nxt;
`else
      result_done = idx_nxt;
`endif
      if (!result_en) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = (out != 4'd0) ? READ : DRAIN;
            READ:    if (k == cnt - 4'd1) state_nxt = DRAIN;
            DRAIN:   if (!(|(tag_v & DRAIN_MASK))) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Tag pipeline: one (valid, index) entry per issued read, aligned so the
   // entry reaches the last stage in the cycle its qp word is valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v <= '0;
         for (int i = 0; i < PL; i++) tag_i[i] <= 4'd0;
      end else begin
         tag_v    <= result_en ? {tag_v[PL-2:0], (state == READ)} : '0;
         tag_i[0] <= k;
         for (int i = 1; i < PL; i++) tag_i[i] <= tag_i[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         re_p          <= 1'b0;
         read_addressp <= '0;
         STOP          <= 1'b0;
         RESULT        <= 4'd0;
         max_val       <= MOST_NEG;
         k             <= 4'd0;
         cnt           <= 4'd0;
         base          <= '0;
      end else if (!result_en) begin
         // Abort: RESULT/max_val deliberately keep whatever was reached.
         re_p <= 1'b0;
         STOP <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               k       <= 4'd0;
               cnt     <= out;
               base    <= memstartzap;
               max_val <= MOST_NEG;
               RESULT  <= 4'd0;
               STOP    <= 1'b0;
               re_p    <= 1'b0;
            end
            READ: begin
               re_p          <= 1'b1;
               read_addressp <= base + SIZE_address_pix'(k);
               k             <= k + 4'd1;
               max_val       <= max_nxt;
               RESULT        <= idx_nxt;
            end
            DRAIN: begin
               re_p    <= 1'b0;
               max_val <= max_nxt;
               RESULT  <= idx_nxt;
            end
            DONE: begin
               re_p    <= 1'b0;
               STOP    <= 1'b1;
               max_val <= max_nxt;
               RESULT  <= result_done;
            end
            default: re_p <= 1'b0;
         endcase
      end
   end

endmodule
